// File: rtl/keyscan_pkg.sv
// Shared types and helpers for the 4x4 key matrix scanner.
// Frame classification, FSM states and matrix geometry.
package keyscan_pkg;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int KEY_CODE_W = 4;
  localparam int FRAME_W    = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_e;

  // Zero bits, exactly one bit, or several bits set.
  function automatic frame_e classify(
    input logic [FRAME_W-1:0] f
  );
    if (f == '0) return NONE;
    if ((f & (f - FRAME_W'(1))) == '0) return SINGLE;
    return MULTI;
  endfunction

  // Index of the highest set bit (the only one for a SINGLE frame).
  function automatic logic [KEY_CODE_W-1:0] key_index(
    input logic [FRAME_W-1:0] f
  );
    logic [KEY_CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      if (f[i]) idx = KEY_CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan tick prescaler: one-cycle tick every CLK_DIV clocks.
// Tick is high while the count sits at CLK_DIV-1.
module scan_tick_gen #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk_50M,
  input  logic rst_n,
  output logic tick
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Wrap to zero on the tick cycle, otherwise count up.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + W'(1);
  end

  // Prescaler count register.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/matrix_key_scanner.sv
// 4x4 key matrix scanner: row drive, column sync, frame snapshot,
// debounce FSM and single-key press reporting without rollover.
module matrix_key_scanner
  import keyscan_pkg::*;
#(
  parameter int CLK_DIV         = 50000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic                  clk_50M,
  input  logic                  rst_n,
  output logic [ROWS-1:0]       ROW,
  input  logic [COLS-1:0]       COL,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam int RW = $clog2(ROWS);

  logic tick;

  scan_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .tick    (tick)
  );

  logic [COLS-1:0]       col_s1_q, col_s2_q;
  logic [RW-1:0]         row_q, row_d;
  logic [ROWS-1:0]       row_drv_q, row_drv_d;
  logic [FRAME_W-1:0]    snap_q, snap_d;
  logic                  frame_end;
  frame_e                fclass;
  logic [KEY_CODE_W-1:0] fcode;
  state_e                state_q, state_d;
  logic [KEY_CODE_W-1:0] cand_q, cand_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic                  match;
  logic                  accept;
  logic                  valid_q;
  logic [KEY_CODE_W-1:0] code_q;

  assign ROW       = row_drv_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;

  // Two-flop synchronizer on the asynchronous column inputs.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q <= '1;
      col_s2_q <= '1;
    end else begin
      col_s1_q <= COL;
      col_s2_q <= col_s1_q;
    end
  end

  // On each tick: capture the active row, then advance to the next row.
  always_comb begin
    row_d     = row_q;
    row_drv_d = row_drv_q;
    snap_d    = snap_q;
    if (tick) begin
      snap_d[{row_q, 2'b00} +: COLS] = ~col_s2_q;
      row_d     = row_q + RW'(1);
      row_drv_d = ~(ROWS'(1) << row_d);
    end
  end

  // Row sequencer and frame snapshot registers.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= '0;
      row_drv_q <= 4'b1110;
      snap_q    <= '0;
    end else begin
      row_q     <= row_d;
      row_drv_q <= row_drv_d;
      snap_q    <= snap_d;
    end
  end

  // Classify the frame including the row just sampled.
  always_comb begin
    frame_end = tick && (row_q == RW'(ROWS - 1));
    fclass    = classify(snap_d);
    fcode     = key_index(snap_d);
    match     = (fclass == SINGLE) && (fcode == cand_q);
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  end

  // FSM state register.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state, advanced only at frame end.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (fclass == SINGLE) begin
            cand_d  = fcode;
            cnt_d   = CNT_ONE;
            state_d = (DEBOUNCE_FRAMES == 1) ? PRESSED : DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (match) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) state_d = PRESSED;
          end else if (fclass == SINGLE) begin
            cand_d = fcode;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (match) begin
            cnt_d = '0;
          end else if (DEBOUNCE_FRAMES == 1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = DEB_RELEASE;
            cnt_d   = CNT_ONE;
          end
        end
        DEB_RELEASE: begin
          if (match) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: a fresh press only from IDLE/DEB_PRESS, never on re-entry.
  always_comb begin
    key_held = (state_q == PRESSED) || (state_q == DEB_RELEASE);
    accept   = frame_end && (state_d == PRESSED) &&
               ((state_q == IDLE) || (state_q == DEB_PRESS));
  end

  // Registered one-clock strobe and held key code.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      valid_q <= accept;
      if (accept) code_q <= cand_d;
    end
  end

endmodule
